// File: rtl/sb_rx_msg_pkg.sv
// sb_rx_msg_pkg: shared message codes, header field positions and decoded-message type
package sb_rx_msg_pkg;
  localparam logic [7:0] MSG_NOP = 8'd0;
  localparam logic [7:0] MSG_REQ = 8'd1;
  localparam logic [7:0] MSG_RESP = 8'd2;
  localparam int CODE_LSB = 14;
  localparam int SUB_LSB = 32;
  localparam int INFO_LSB = 40;
  localparam int PAR_BIT = 63;
  typedef struct packed {
    logic [7:0] ch;
    logic [7:0] code;
    logic [7:0] sub_code;
    logic [15:0] info;
  } msg_t;
endpackage

// File: rtl/sb_rx_msg_fifo.sv
// sb_rx_msg_fifo: synchronous show-ahead FIFO with wrap-bit pointers
module sb_rx_msg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last;
  logic [AW:0] wptr, rptr;
  logic we, re;
  assign empty = wptr == rptr;
  assign full = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign count = wptr - rptr;
  assign re = pop && !empty;
  assign we = push && (!full || re);
  assign rdata = empty ? last : mem[rptr[AW-1:0]];
  // pointers advance on accepted push/pop; the popped head is kept so outputs hold when empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      last <= '0;
    end else begin
      wptr <= wptr + (AW+1)'(we);
      rptr <= rptr + (AW+1)'(re);
      if (re) last <= mem[rptr[AW-1:0]];
    end
  // storage array needs no reset; it is only visible through a non-empty head
  always_ff @(posedge clk)
    if (we) mem[wptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/sb_rx_msg_decoder.sv
// sb_rx_msg_decoder: checks, decodes and queues sideband RX message headers per channel
module sb_rx_msg_decoder
  import sb_rx_msg_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int INFO_W = 2,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_hdr_valid,
  input  logic [CH_W-1:0]   i_hdr_ch,
  input  logic [63:0]       i_header,
  output logic              o_msg_valid,
  input  logic              i_msg_ready,
  output logic [CH_W-1:0]   o_msg_ch,
  output logic [7:0]        o_msg_code,
  output logic [7:0]        o_msg_sub_code,
  output logic [INFO_W-1:0] o_msg_info,
  output logic              o_parity_err,
  output logic              o_unsup_err,
  output logic              o_overflow,
  output logic [CNT_W-1:0]  o_fifo_count
);
  logic [7:0] code;
  logic [INFO_W-1:0] norm_info;
  logic par_err, bad_code, bad_ch, unsup;
  logic stg_valid, stg_par, stg_unsup;
  msg_t stg_msg, head;
  logic good, full, empty, pop, push;
  logic unused_head;
  assign code = i_header[CODE_LSB +: 8];
  // parity has priority; unsupported covers unknown codes and out-of-range channels
  always_comb begin
    par_err = ^{i_header[PAR_BIT], i_header[PAR_BIT-1:0]};
    bad_code = !(code == MSG_NOP || code == MSG_REQ || code == MSG_RESP);
    bad_ch = 32'(i_hdr_ch) >= NUM_CH;
    unsup = !par_err && (bad_code || bad_ch);
    norm_info = code == MSG_NOP ? i_header[INFO_LSB +: INFO_W] :
                code == MSG_RESP ? INFO_W'(i_header[INFO_LSB]) : '0;
  end
  // decode register: one header per cycle, error flags pulse for a single cycle
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      stg_valid <= 1'b0;
      stg_par <= 1'b0;
      stg_unsup <= 1'b0;
      stg_msg <= '0;
    end else begin
      stg_valid <= i_hdr_valid;
      stg_par <= i_hdr_valid && par_err;
      stg_unsup <= i_hdr_valid && unsup;
      if (i_hdr_valid)
        stg_msg <= '{ch: 8'(i_hdr_ch), code: code, sub_code: i_header[SUB_LSB +: 8], info: 16'(norm_info)};
    end
  assign good = stg_valid && !stg_par && !stg_unsup;
  assign pop = !empty && i_msg_ready;
  assign push = good && (!full || pop);
  assign o_overflow = good && full && !pop;
  assign o_parity_err = stg_par;
  assign o_unsup_err = stg_unsup;
  sb_rx_msg_fifo #(.WIDTH($bits(msg_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(i_clk),
    .rst_n(i_rst_n),
    .push(push),
    .wdata(stg_msg),
    .pop(pop),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(o_fifo_count)
  );
  assign o_msg_valid = !empty;
  assign o_msg_ch = head.ch[CH_W-1:0];
  assign o_msg_code = head.code;
  assign o_msg_sub_code = head.sub_code;
  assign o_msg_info = head.info[INFO_W-1:0];
  assign unused_head = ^{head.ch, head.info};
endmodule

// File: tb/tb_sb_rx_msg_decoder.sv
// tb_sb_rx_msg_decoder: directed table plus multi-cycle sequences for the RX message decoder
module tb_sb_rx_msg_decoder;
  logic clk = 1'b0, rst_n = 1'b0, hdr_valid = 1'b0, msg_ready = 1'b0;
  logic [1:0] hdr_ch = '0;
  logic [63:0] header = '0;
  logic msg_valid, par_err, unsup_err, overflow;
  logic [1:0] msg_ch, msg_info;
  logic [7:0] msg_code, msg_sub;
  logic [2:0] fifo_count;
  int checks = 0, errors = 0;
  typedef struct {
    logic [7:0] code;
    logic [7:0] sub;
    logic [15:0] info;
    logic [1:0] ch;
    logic bad;
    logic e_par;
    logic e_unsup;
    logic e_valid;
    logic [1:0] e_info;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  sb_rx_msg_decoder #(.NUM_CH(3), .FIFO_DEPTH(4), .INFO_W(2)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_hdr_valid(hdr_valid),
    .i_hdr_ch(hdr_ch),
    .i_header(header),
    .o_msg_valid(msg_valid),
    .i_msg_ready(msg_ready),
    .o_msg_ch(msg_ch),
    .o_msg_code(msg_code),
    .o_msg_sub_code(msg_sub),
    .o_msg_info(msg_info),
    .o_parity_err(par_err),
    .o_unsup_err(unsup_err),
    .o_overflow(overflow),
    .o_fifo_count(fifo_count)
  );

  function automatic logic [63:0] mk(input logic [7:0] code, input logic [7:0] sub,
                                     input logic [15:0] info, input logic bad);
    logic [63:0] h;
    h = '0;
    h[21:14] = code;
    h[39:32] = sub;
    h[55:40] = info;
    h[63] = ^h[62:0];
    if (bad) h[0] = ~h[0];
    return h;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hdr(input logic [63:0] h, input logic [1:0] ch);
    header = h;
    hdr_ch = ch;
    hdr_valid = 1'b1;
    step();
    hdr_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h02, 8'h03, 16'h0003, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
    vecs[1] = '{8'h00, 8'h11, 16'hFFFE, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10};
    vecs[2] = '{8'h01, 8'h22, 16'hFFFF, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
    vecs[3] = '{8'h02, 8'h33, 16'h0002, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
    vecs[4] = '{8'h00, 8'hA5, 16'h0001, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
    vecs[5] = '{8'h02, 8'h03, 16'h0003, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
    vecs[6] = '{8'h03, 8'h00, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[7] = '{8'h00, 8'h00, 16'h0000, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
    vecs[8] = '{8'h03, 8'h00, 16'h0000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
    vecs[9] = '{8'hFF, 8'h5A, 16'h1234, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
    #1;
    chk("rst_valid", msg_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_errs", {par_err, unsup_err, overflow}, 0);
    chk("rst_fields", {msg_ch, msg_code, msg_sub, msg_info}, 0);
    #11 rst_n = 1'b1;
    step();
    msg_ready = 1'b1;
    foreach (vecs[i]) begin
      hdr(mk(vecs[i].code, vecs[i].sub, vecs[i].info, vecs[i].bad), vecs[i].ch);
      chk($sformatf("v%0d_par", i), par_err, vecs[i].e_par);
      chk($sformatf("v%0d_unsup", i), unsup_err, vecs[i].e_unsup);
      chk($sformatf("v%0d_valid_n1", i), msg_valid, 0);
      chk($sformatf("v%0d_ovf", i), overflow, 0);
      step();
      chk($sformatf("v%0d_valid_n2", i), msg_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_err_clear", i), {par_err, unsup_err}, 0);
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_code", i), msg_code, vecs[i].code);
        chk($sformatf("v%0d_sub", i), msg_sub, vecs[i].sub);
        chk($sformatf("v%0d_info", i), msg_info, vecs[i].e_info);
        chk($sformatf("v%0d_ch", i), msg_ch, vecs[i].ch);
      end else chk($sformatf("v%0d_count", i), fifo_count, 0);
      step();
      chk($sformatf("v%0d_popped", i), msg_valid, 0);
    end
    // back-to-back Nop then Req
    hdr(mk(8'h00, 8'h01, 16'hFFFE, 1'b0), 2'd0);
    hdr(mk(8'h01, 8'h02, 16'hFFFF, 1'b0), 2'd1);
    chk("b2b_first_valid", msg_valid, 1);
    chk("b2b_first_info", msg_info, 2'b10);
    chk("b2b_first_sub", msg_sub, 8'h01);
    step();
    chk("b2b_second_valid", msg_valid, 1);
    chk("b2b_second_info", msg_info, 2'b00);
    chk("b2b_second_sub", msg_sub, 8'h02);
    step();
    chk("b2b_drained", msg_valid, 0);
    // overflow with consumer stalled
    msg_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        header = mk(8'h02, 8'(i + 1), 16'(i + 1), 1'b0);
        hdr_ch = 2'd0;
        hdr_valid = 1'b1;
      end else hdr_valid = 1'b0;
      step();
      chk($sformatf("ovf_cycle%0d", i + 1), overflow, (i == 4 || i == 5) ? 1 : 0);
    end
    chk("ovf_count_sat", fifo_count, 4);
    msg_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovf_drain%0d_valid", k), msg_valid, 1);
      chk($sformatf("ovf_drain%0d_sub", k), msg_sub, k);
      chk($sformatf("ovf_drain%0d_info", k), msg_info, k & 1);
      step();
    end
    chk("ovf_drain_empty", msg_valid, 0);
    chk("ovf_drain_count", fifo_count, 0);
    // push and pop together at full
    msg_ready = 1'b0;
    for (int k = 1; k <= 4; k++) hdr(mk(8'h02, 8'(k), 16'h0000, 1'b0), 2'd1);
    step();
    chk("full_count", fifo_count, 4);
    hdr(mk(8'h02, 8'h05, 16'h0000, 1'b0), 2'd1);
    msg_ready = 1'b1;
    #1;
    chk("full_pp_no_ovf", overflow, 0);
    step();
    msg_ready = 1'b0;
    chk("full_pp_count", fifo_count, 4);
    chk("full_pp_head", msg_sub, 8'h02);
    msg_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("full_drain%0d", k), msg_sub, k);
      step();
    end
    chk("full_drain_empty", msg_valid, 0);
    // asynchronous reset with entries queued
    msg_ready = 1'b0;
    for (int k = 1; k <= 3; k++) hdr(mk(8'h00, 8'(k), 16'h0003, 1'b0), 2'd2);
    step();
    chk("pre_rst_count", fifo_count, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", msg_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_fields", {msg_ch, msg_code, msg_sub, msg_info}, 0);
    chk("mid_rst_errs", {par_err, unsup_err, overflow}, 0);
    #3 rst_n = 1'b1;
    step();
    hdr(mk(8'h02, 8'h77, 16'h0001, 1'b0), 2'd1);
    chk("post_rst_n1", msg_valid, 0);
    step();
    chk("post_rst_valid", msg_valid, 1);
    chk("post_rst_count", fifo_count, 1);
    chk("post_rst_sub", msg_sub, 8'h77);
    chk("post_rst_ch", msg_ch, 2'd1);
    chk("post_rst_info", msg_info, 2'b01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
